// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI master.
package spi_pkg;
  localparam int SPI_BITS = 8;
  localparam int CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD,
    GAP
  } spi_state_e;
endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV clk cycles per half-period, idles low whenever not running.
// Edge ticks are high in the cycle whose closing clk edge toggles SCK.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic SCK,
  output logic rise_tick,
  output logic fall_tick
);

  logic [CNT_W-1:0] hp_cnt;
  logic             tick;

  assign tick      = run && (hp_cnt == CNT_W'(CLK_DIV - 1));
  assign rise_tick = tick && !SCK;
  assign fall_tick = tick && SCK;

  always_ff @(posedge clk) begin
    if (rst || restart || !run) begin
      hp_cnt <= '0;
      SCK    <= 1'b0;
    end else if (tick) begin
      hp_cnt <= '0;
      SCK    <= ~SCK;
    end else begin
      hp_cnt <= hp_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master, MSB first, byte-wide valid/ready fabric side.
// SSEL stays low across bytes until a byte tagged last has been shifted.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                tx_last,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                SCK,
  output logic                MOSI,
  input  logic                MISO,
  output logic                SSEL
);

  spi_state_e          state, state_n;
  logic [SPI_BITS-1:0] tx_shift, rx_shift, rx_next;
  logic [2:0]          bitcnt;
  logic [CNT_W-1:0]    gap_cnt;
  logic                last_q, idle_ok;
  logic                miso_s1, miso_s2;
  logic [1:0]          smp_pipe;
  logic                accept, gap_done, run, rise_tick, fall_tick;

  assign accept   = tx_valid && tx_ready;
  assign gap_done = (gap_cnt == CNT_W'(CS_GAP - 1));
  assign run      = (state == SHIFT);
  assign busy     = (state != IDLE);

  // MISO is captured two cycles after the SCK rising tick so the sampled bit is
  // the pin value at the rising edge, independent of the synchronizer delay.
  assign rx_next = smp_pipe[1] ? {rx_shift[SPI_BITS-2:0], miso_s2} : rx_shift;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .restart  (accept),
    .SCK      (SCK),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_comb begin
    state_n  = state;
    tx_ready = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = idle_ok;
        if (tx_valid && idle_ok) state_n = SETUP;
      end
      SETUP: if (gap_done) state_n = SHIFT;
      SHIFT: if (fall_tick && bitcnt == 3'd7) state_n = last_q ? HOLD : NEXT;
      NEXT: begin
        tx_ready = 1'b1;
        if (tx_valid) state_n = SHIFT;
      end
      HOLD:    if (gap_done) state_n = GAP;
      GAP:     if (gap_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      SSEL     <= 1'b1;
      MOSI     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      bitcnt   <= '0;
      gap_cnt  <= '0;
      last_q   <= 1'b0;
      idle_ok  <= 1'b0;
      miso_s1  <= 1'b0;
      miso_s2  <= 1'b0;
      smp_pipe <= '0;
    end else begin
      state    <= state_n;
      miso_s1  <= MISO;
      miso_s2  <= miso_s1;
      smp_pipe <= {smp_pipe[0], rise_tick};
      rx_shift <= rx_next;
      rx_valid <= 1'b0;

      if (state_n != state) gap_cnt <= '0;
      else if (!gap_done)   gap_cnt <= gap_cnt + 1'b1;

      if (accept) begin
        tx_shift <= tx_data;
        last_q   <= tx_last;
        bitcnt   <= '0;
        MOSI     <= tx_data[SPI_BITS-1];
        SSEL     <= 1'b0;
      end

      if (fall_tick) begin
        bitcnt <= bitcnt + 1'b1;
        if (bitcnt != 3'd7) begin
          tx_shift <= tx_shift << 1;
          MOSI     <= tx_shift[SPI_BITS-2];
        end else begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end

      if (state == HOLD && gap_done) SSEL <= 1'b1;
      if (state == GAP && gap_done) begin
        MOSI    <= 1'b0;
        idle_ok <= 1'b1;
      end
      // After reset the select must still stay high CS_GAP cycles before a message.
      if (state == IDLE && !idle_ok && gap_done) idle_ok <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, multi-byte, slave model, stall, reset abort, CLK_DIV=2.
module tb_spi_master;
  localparam int CS_GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = '0, rx_data;
  logic       tx_last = 1'b0, tx_valid = 1'b0;
  logic       tx_ready, rx_valid, busy, sck, mosi, miso, ssel;
  logic       loop = 1'b0, slv_miso = 1'b0;
  assign miso = loop ? mosi : slv_miso;

  spi_master #(.CLK_DIV(4), .CS_GAP(CS_GAP)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel)
  );

  logic [7:0] tx2_data = '0, rx2_data;
  logic       tx2_valid = 1'b0, tx2_ready, rx2_valid, busy2, sck2, mosi2, ssel2;

  spi_master #(.CLK_DIV(2), .CS_GAP(CS_GAP)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx2_data), .tx_last(1'b1), .tx_valid(tx2_valid),
    .tx_ready(tx2_ready), .rx_data(rx2_data), .rx_valid(rx2_valid), .busy(busy2),
    .SCK(sck2), .MOSI(mosi2), .MISO(mosi2), .SSEL(ssel2)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // u0 monitor, sampled on the active edge so it sees settled register values
  int         rise_cnt = 0, ssel_falls = 0, rxv_cnt = 0;
  int         cur_low = 0, cur_high = 0, last_low = 0, last_high = 0;
  logic       sck_d = 1'b0, ssel_d = 1'b1;
  logic [7:0] rx_log[$];

  always @(posedge clk) begin
    sck_d  <= sck;
    ssel_d <= ssel;
    if (sck && !sck_d) rise_cnt <= rise_cnt + 1;
    if (!ssel && ssel_d) ssel_falls <= ssel_falls + 1;
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_log.push_back(rx_data);
    end
    if (!ssel) begin
      cur_low <= cur_low + 1;
      if (cur_high != 0) begin last_high <= cur_high; cur_high <= 0; end
    end else begin
      cur_high <= cur_high + 1;
      if (cur_low != 0) begin last_low <= cur_low; cur_low <= 0; end
    end
  end

  // u2 monitor: SCK high/low run lengths and rx pulse count
  int   run2 = 0, hmin2 = 99, hmax2 = 0, lmin2 = 99, lmax2 = 0, rx2v_cnt = 0;
  logic sck2_d = 1'b0, seen2 = 1'b0;

  always @(posedge clk) begin
    sck2_d <= sck2;
    if (rx2_valid) rx2v_cnt <= rx2v_cnt + 1;
    if (sck2 !== sck2_d) begin
      run2 <= 1;
      if (!sck2) begin
        seen2 <= 1'b1;
        if (run2 < hmin2) hmin2 <= run2;
        if (run2 > hmax2) hmax2 <= run2;
      end else if (seen2) begin
        if (run2 < lmin2) lmin2 <= run2;
        if (run2 > lmax2) lmax2 <= run2;
      end
    end else begin
      run2 <= run2 + 1;
    end
  end

  // Mode-0 slave: first byte is the count of completed messages, then zeros
  logic       s_ssel_d = 1'b1, s_sck_d = 1'b0;
  logic [7:0] s_sreg = '0;
  int         s_msgs = 0;

  always @(ssel or sck) begin
    if (ssel === 1'b0 && s_ssel_d === 1'b1) begin
      s_sreg   = s_msgs[7:0];
      slv_miso = s_sreg[7];
    end else if (ssel === 1'b1 && s_ssel_d === 1'b0 && !rst) begin
      s_msgs = s_msgs + 1;
    end else if (ssel === 1'b0 && sck === 1'b0 && s_sck_d === 1'b1) begin
      s_sreg   = s_sreg << 1;
      slv_miso = s_sreg[7];
    end
    s_ssel_d = ssel;
    s_sck_d  = sck;
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) chk(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int r0, f0, v0, b0, n, bad;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ssel", ssel, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxdata", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gap_ready", tx_ready, 0);

    // slave model: two 2-byte messages
    loop = 1'b0;
    b0 = rx_log.size();
    send(8'hC1, 1'b0); send(8'hC2, 1'b1); wait_idle("slv_m1_idle");
    send(8'hC3, 1'b0); send(8'hC4, 1'b1); wait_idle("slv_m2_idle");
    chk("slv_cnt", rx_log.size() - b0, 4);
    chk("slv_b0", rx_log[b0], 8'h00);
    chk("slv_b1", rx_log[b0+1], 8'h00);
    chk("slv_b2", rx_log[b0+2], 8'h01);
    chk("slv_b3", rx_log[b0+3], 8'h00);
    chk("slv_gap", 32'(last_high >= CS_GAP), 1);

    // single byte loopback
    loop = 1'b1;
    r0 = rise_cnt; f0 = ssel_falls; v0 = rxv_cnt;
    send(8'hA5, 1'b1); wait_idle("a5_idle");
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_pulses", rxv_cnt - v0, 1);
    chk("a5_rises", rise_cnt - r0, 8);
    chk("a5_ssel_low", last_low, 2*CS_GAP + 64);
    chk("a5_ssel_falls", ssel_falls - f0, 1);

    // three bytes back-to-back
    r0 = rise_cnt; f0 = ssel_falls; b0 = rx_log.size();
    send(8'h01, 1'b0); send(8'hFF, 1'b0); send(8'h80, 1'b1); wait_idle("m3_idle");
    chk("m3_rises", rise_cnt - r0, 24);
    chk("m3_ssel_falls", ssel_falls - f0, 1);
    chk("m3_cnt", rx_log.size() - b0, 3);
    chk("m3_b0", rx_log[b0], 8'h01);
    chk("m3_b1", rx_log[b0+1], 8'hFF);
    chk("m3_b2", rx_log[b0+2], 8'h80);

    // 50-cycle stall in NEXT
    r0 = rise_cnt; b0 = rx_log.size();
    send(8'h96, 1'b0);
    n = 0;
    while (!(tx_ready && busy) && n < 2000) begin @(negedge clk); n++; end
    chk("stall_reach_next", 32'(tx_ready && busy), 1);
    bad = 0;
    repeat (50) begin
      if (sck !== 1'b0 || ssel !== 1'b0 || tx_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("stall_hold", bad, 0);
    send(8'h69, 1'b1); wait_idle("stall_idle");
    chk("stall_rises", rise_cnt - r0, 16);
    chk("stall_b0", rx_log[b0], 8'h96);
    chk("stall_b1", rx_log[b0+1], 8'h69);

    // reset after third rising edge
    r0 = rise_cnt; v0 = rxv_cnt;
    send(8'hC3, 1'b1);
    n = 0;
    while (rise_cnt < r0 + 3 && n < 2000) begin @(negedge clk); n++; end
    chk("abort_reach", 32'(rise_cnt - r0), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ssel", ssel, 1);
    chk("abort_sck", sck, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_rxv", rx_valid, 0);
    chk("abort_rxdata", rx_data, 8'h00);
    chk("abort_ready", tx_ready, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_pulse", rxv_cnt - v0, 0);
    send(8'h3C, 1'b1); wait_idle("abort_idle");
    chk("abort_next", rx_data, 8'h3C);

    // CLK_DIV=2 loopback on the second instance
    tx2_data = 8'h5A; tx2_valid = 1'b1;
    n = 0;
    while (!tx2_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    tx2_valid = 1'b0;
    n = 0;
    while (busy2 && n < 2000) begin @(negedge clk); n++; end
    chk("div2_idle", busy2, 0);
    chk("div2_data", rx2_data, 8'h5A);
    chk("div2_pulses", rx2v_cnt, 1);
    chk("div2_hmin", hmin2, 2);
    chk("div2_hmax", hmax2, 2);
    chk("div2_lmin", lmin2, 2);
    chk("div2_lmax", lmax2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
